// File: rtl/dev_bus_arbiter.sv
// Two-master round-robin arbiter for the device bus (Bridge Pr-side port).
// It checks each address against the device window and inserts fixed wait states before a one-cycle ack.
module dev_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES   = 2,
  parameter logic [31:0] DEV_BASE      = 32'h0000_7F00,
  parameter int unsigned DEV_SPAN_LOG2 = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [29:0] m0_addr,
  input  logic [31:0] m0_wd,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [29:0] m1_addr,
  input  logic [31:0] m1_wd,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [29:0] pr_addr,
  output logic [31:0] pr_wd,
  output logic        pr_we,
  input  logic [31:0] pr_rd,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_ACK
  } state_e;

  localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] WIN_TAG  = DEV_BASE >> DEV_SPAN_LOG2;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        last_gnt_q;
  logic        gnt_q;
  logic        we_q;
  logic [29:0] pr_addr_q;
  logic [31:0] pr_wd_q;
  logic        pr_we_q;
  logic [31:0] rdata_q;
  logic        m0_ack_q, m1_ack_q;
  logic        m0_err_q, m1_err_q;
  logic        busy_q;

  // Grant selection and window decode for the candidate master.
  logic        sel_valid;
  logic        sel_id;
  logic        sel_we;
  logic [29:0] sel_addr;
  logic [31:0] sel_wd;
  logic        sel_in_win;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    sel_valid  = m0_req | m1_req;
    sel_id     = (m0_req && m1_req) ? ~last_gnt_q : m1_req;
    sel_we     = sel_id ? m1_we   : m0_we;
    sel_addr   = sel_id ? m1_addr : m0_addr;
    sel_wd     = sel_id ? m1_wd   : m0_wd;
    sel_in_win = (({sel_addr, 2'b00}) >> DEV_SPAN_LOG2) == WIN_TAG;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      pr_addr_q  <= '0;
      pr_wd_q    <= '0;
      pr_we_q    <= 1'b0;
      rdata_q    <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel_valid) begin
            gnt_q      <= sel_id;
            last_gnt_q <= sel_id;
            we_q       <= sel_we;
            busy_q     <= 1'b1;
            if (sel_in_win) begin
              state_q   <= S_BUSY;
              cnt_q     <= CNT_INIT;
              pr_addr_q <= sel_addr;
              pr_wd_q   <= sel_wd;
              pr_we_q   <= sel_we;
            end else begin
              // Out-of-window requests skip the bus entirely and complete with an error.
              state_q  <= S_ACK;
              rdata_q  <= '0;
              m0_ack_q <= ~sel_id;
              m1_ack_q <= sel_id;
              m0_err_q <= ~sel_id;
              m1_err_q <= sel_id;
            end
          end
        end
        S_BUSY: begin
          pr_we_q <= 1'b0;
          if (cnt_q == 4'd0) begin
            state_q   <= S_ACK;
            pr_addr_q <= '0;
            pr_wd_q   <= '0;
            rdata_q   <= we_q ? 32'd0 : pr_rd;
            m0_ack_q  <= ~gnt_q;
            m1_ack_q  <= gnt_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACK: begin
          state_q  <= S_IDLE;
          rdata_q  <= '0;
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          m0_err_q <= 1'b0;
          m1_err_q <= 1'b0;
          busy_q   <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_err   = m0_err_q;
  assign m1_err   = m1_err_q;
  assign m0_rdata = rdata_q;
  assign m1_rdata = rdata_q;
  assign pr_addr  = pr_addr_q;
  assign pr_wd    = pr_wd_q;
  assign pr_we    = pr_we_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Directed bench for dev_bus_arbiter: a WAIT_CYCLES=2 instance for most cases and a WAIT_CYCLES=1 instance.
// Inputs are driven and outputs sampled on the falling edge.
module tb_dev_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance a: WAIT_CYCLES = 2
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [29:0] m0_addr, m1_addr;
  logic [31:0] m0_wd, m1_wd, pr_rd;
  logic        m0_ack, m0_err, m1_ack, m1_err, pr_we, busy;
  logic [31:0] m0_rdata, m1_rdata, pr_wd;
  logic [29:0] pr_addr;

  // Instance b: WAIT_CYCLES = 1
  logic        b_m0_req, b_m0_we, b_m1_req, b_m1_we;
  logic [29:0] b_m0_addr, b_m1_addr;
  logic [31:0] b_m0_wd, b_m1_wd, b_pr_rd;
  logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_pr_we, b_busy;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_pr_wd;
  logic [29:0] b_pr_addr;

  dev_bus_arbiter #(.WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .pr_addr(pr_addr), .pr_wd(pr_wd), .pr_we(pr_we), .pr_rd(pr_rd), .busy(busy)
  );

  dev_bus_arbiter #(.WAIT_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wd(b_m0_wd),
    .m0_ack(b_m0_ack), .m0_err(b_m0_err), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wd(b_m1_wd),
    .m1_ack(b_m1_ack), .m1_err(b_m1_err), .m1_rdata(b_m1_rdata),
    .pr_addr(b_pr_addr), .pr_wd(b_pr_wd), .pr_we(b_pr_we), .pr_rd(b_pr_rd), .busy(b_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  int ack_cyc[4];
  int ack_id[4];
  int n_ack;
  int cyc;

  initial begin
    reset = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wd = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wd = '0;
    pr_rd = 32'hDEAD_BEEF;
    b_m0_req = 0; b_m0_we = 0; b_m0_addr = '0; b_m0_wd = '0;
    b_m1_req = 0; b_m1_we = 0; b_m1_addr = '0; b_m1_wd = '0;
    b_pr_rd = 32'h1234_5678;
    tick(); tick();
    check("rst_busy",  busy, 0);
    check("rst_acks",  {m0_ack, m1_ack, m0_err, m1_err}, 0);
    check("rst_pr",    {pr_we, pr_addr}, 0);
    check("rst_rdata", m0_rdata | m1_rdata, 0);
    reset = 1'b0;

    // 1. M0 read 0x7F04
    m0_req = 1; m0_we = 0; m0_addr = 30'h1FC1;
    tick();
    check("t1_c1_busy", busy, 1);
    check("t1_c1_addr", pr_addr, 30'h1FC1);
    check("t1_c1_we",   pr_we, 0);
    check("t1_c1_ack",  m0_ack, 0);
    tick();
    check("t1_c2_addr", pr_addr, 30'h1FC1);
    check("t1_c2_ack",  m0_ack, 0);
    tick();
    check("t1_ack",     m0_ack, 1);
    check("t1_m1ack",   m1_ack, 0);
    check("t1_err",     m0_err, 0);
    check("t1_rdata",   m0_rdata, 32'hDEAD_BEEF);
    check("t1_m1rdata", m1_rdata, 32'hDEAD_BEEF);
    check("t1_addr0",   pr_addr, 0);
    m0_req = 0;
    tick();
    check("t1_idle_ack",  m0_ack, 0);
    check("t1_idle_busy", busy, 0);

    // 2. M1 write 0x7F10, wd=5
    m1_req = 1; m1_we = 1; m1_addr = 30'h1FC4; m1_wd = 32'd5;
    tick();
    check("t2_c1_we",   pr_we, 1);
    check("t2_c1_addr", pr_addr, 30'h1FC4);
    check("t2_c1_wd",   pr_wd, 32'd5);
    tick();
    check("t2_c2_we",   pr_we, 0);
    check("t2_c2_ack",  m1_ack, 0);
    tick();
    check("t2_ack",     m1_ack, 1);
    check("t2_m0ack",   m0_ack, 0);
    check("t2_err",     m1_err, 0);
    check("t2_rdata",   m1_rdata, 0);
    check("t2_we",      pr_we, 0);
    m1_req = 0; m1_we = 0;
    tick();
    check("t2_idle", {m1_ack, busy}, 0);

    // 3. Constant contention from reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m0_req = 1; m0_we = 0; m0_addr = 30'h1FC1;
    m1_req = 1; m1_we = 0; m1_addr = 30'h1FC5;
    n_ack = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (m0_ack && m1_ack) check("t3_overlap", {m0_ack, m1_ack}, 2'b01);
      else if (m0_ack || m1_ack) begin
        if (n_ack < 4) begin
          ack_cyc[n_ack] = c;
          ack_id[n_ack]  = int'(m1_ack);
        end
        n_ack++;
      end
    end
    m0_req = 0; m1_req = 0;
    check("t3_nack", n_ack, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_id%0d", k),  ack_id[k],  k % 2);
      check($sformatf("t3_cyc%0d", k), ack_cyc[k], 3 + 4 * k);
    end
    tick(); tick();

    // 4. Out-of-window read 0x0000_3000
    m0_req = 1; m0_we = 0; m0_addr = 30'h0C00;
    tick();
    check("t4_ack",   m0_ack, 1);
    check("t4_err",   m0_err, 1);
    check("t4_m1",    {m1_ack, m1_err}, 0);
    check("t4_rdata", m0_rdata, 0);
    check("t4_pr",    {pr_we, pr_addr}, 0);
    check("t4_wd",    pr_wd, 0);
    m0_req = 0;
    tick();
    check("t4_idle", {m0_ack, m0_err, busy, pr_we}, 0);

    // 5. Reset during second BUSY cycle of an M1 write
    m1_req = 1; m1_we = 1; m1_addr = 30'h1FC4; m1_wd = 32'hA5;
    tick();
    check("t5_c1_we", pr_we, 1);
    tick();
    check("t5_c2_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_we",   pr_we, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_acks", {m0_ack, m1_ack}, 0);
    check("t5_rst_addr", pr_addr, 0);
    m1_req = 0; m1_we = 0;
    tick();
    check("t5_rst_noack", {m0_ack, m1_ack}, 0);
    reset = 1'b0;
    m0_req = 1; m0_addr = 30'h1FC1; m0_we = 0;
    m1_req = 1; m1_addr = 30'h1FC5; m1_we = 0;
    cyc = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (m0_ack || m1_ack) begin
        cyc = c;
        break;
      end
    end
    if (cyc == 0) check("t5_ack_timeout", 0, 1);
    check("t5_first_m0", {m0_ack, m1_ack}, 2'b10);
    check("t5_cyc", cyc, 3);
    m0_req = 0; m1_req = 0;
    tick(); tick(); tick(); tick();

    // 6. WAIT_CYCLES=1 instance
    b_m0_req = 1; b_m0_we = 0; b_m0_addr = 30'h1FC2;
    tick();
    check("t6_busy", b_busy, 1);
    check("t6_addr", b_pr_addr, 30'h1FC2);
    check("t6_ack0", b_m0_ack, 0);
    b_pr_rd = 32'hA5A5_0001;
    tick();
    check("t6_ack",   b_m0_ack, 1);
    check("t6_rdata", b_m0_rdata, 32'hA5A5_0001);
    b_pr_rd = 32'h0BAD_0BAD;
    #1;
    check("t6_rdata_hold", b_m0_rdata, 32'hA5A5_0001);
    b_m0_req = 0;
    tick();
    check("t6_idle", {b_m0_ack, b_busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
